// File: rtl/jtgng_rom_pkg.sv
// Shared constants for the SDRAM ROM slot reader.
// Slot index width helper and the 1943 ROM base layout.
package jtgng_rom_pkg;

  function automatic int slot_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam logic [21:0] G43_MAIN = 22'h00000;
  localparam logic [21:0] G43_SND  = 22'h14000;
  localparam logic [21:0] G43_CHAR = 22'h18000;
  localparam logic [21:0] G43_MAP1 = 22'h1C000;
  localparam logic [21:0] G43_MAP2 = 22'h20000;
  localparam logic [21:0] G43_SCR1 = 22'h24000;
  localparam logic [21:0] G43_SCR2 = 22'h44000;
  localparam logic [21:0] G43_OBJ  = 22'h4C000;

  // slot 0 in the low bits
  localparam logic [8*22-1:0] G43_OFFSETS = {
    G43_OBJ,  G43_SCR2, G43_SCR1, G43_MAP2,
    G43_MAP1, G43_CHAR, G43_SND,  G43_MAIN
  };

endpackage

// File: rtl/jtgng_rom_slot_cache.sv
// Per-slot state: last read address, valid, byte lsb, data register.
// Ports: addr_i/issue_i latch a read, cap_i stores data_i, skip_o/dout_o/ok_o.
module jtgng_rom_slot_cache #(
  parameter int AW   = 18,
  parameter bit BYTE = 1'b0,
  parameter bit SKIP = 1'b1
)(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cen_i,
  input  logic [AW-1:0] addr_i,
  input  logic          issue_i,
  input  logic          cap_i,
  input  logic [15:0]   data_i,
  output logic          skip_o,
  output logic [15:0]   dout_o,
  output logic          ok_o
);

  logic [AW-1:0] addr_q;
  logic          valid_q;
  logic          lsb_q;
  logic          ok_q;
  logic [15:0]   dout_q;
  logic [15:0]   dout_d;

  // even byte lives in the upper half of the SDRAM word
  always_comb begin
    dout_d = data_i;
    if (BYTE) begin
      dout_d = {8'h00, lsb_q ? data_i[7:0] : data_i[15:8]};
    end
  end

  assign skip_o = SKIP && valid_q && (addr_i == addr_q);
  assign dout_o = dout_q;
  assign ok_o   = ok_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      valid_q <= 1'b0;
      lsb_q   <= 1'b0;
      ok_q    <= 1'b0;
      dout_q  <= '0;
    end else if (cen_i) begin
      ok_q <= cap_i;
      if (cap_i) dout_q <= dout_d;
      if (issue_i) begin
        addr_q  <= addr_i;
        valid_q <= 1'b1;
        lsb_q   <= addr_i[0];
      end
    end
  end

endmodule

// File: rtl/jtgng_rom_slots.sv
// Round-robin SDRAM ROM reader: one slot per cen, skip/refresh, strobes.
// Ports: slot_addr in, slot_dout/slot_ok out, sdram_* to controller.
module jtgng_rom_slots
  import jtgng_rom_pkg::*;
#(
  parameter int                  SLOTS     = 8,
  parameter int                  AW        = 22,
  parameter int                  SLOT_AW   = 18,
  parameter logic [SLOTS*AW-1:0] OFFSETS   = '0,
  parameter logic [SLOTS-1:0]    BYTE_MODE = '0,
  parameter logic [SLOTS-1:0]    SKIP_EN   = '1,
  parameter int                  READY_DLY = 4
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cen,
  input  logic                     slot_sync,
  input  logic                     downloading,
  input  logic                     loop_rst,
  input  logic                     LVBL,
  input  logic [SLOTS*SLOT_AW-1:0] slot_addr,
  output logic [SLOTS*16-1:0]      slot_dout,
  output logic [SLOTS-1:0]         slot_ok,
  output logic [AW-1:0]            sdram_addr,
  output logic                     sdram_re,
  output logic                     sdram_rfsh,
  input  logic [15:0]              data_read,
  output logic                     ready
);

  localparam int SW = slot_w(SLOTS);
  localparam int RW = $clog2(READY_DLY + 1);

  logic               idle;
  logic [SW-1:0]      cnt_q, cnt_d;
  logic [SW-1:0]      pslot_q, pslot_d;
  logic               pend_q, pend_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic               re_q, re_d;
  logic               rfsh_q, rfsh_d;
  logic [RW-1:0]      rdy_q, rdy_d;
  logic               ready_q, ready_d;
  logic [SLOT_AW-1:0] req [SLOTS];
  logic [AW-1:0]      offs [SLOTS];
  logic [SLOTS-1:0]   skip, iss, cap;
  logic [SLOT_AW-1:0] cur, word;
  logic               hit, go;

  assign idle = rst | loop_rst | downloading;

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    assign req[i]  = slot_addr[i*SLOT_AW +: SLOT_AW];
    assign offs[i] = OFFSETS[i*AW +: AW];

    jtgng_rom_slot_cache #(
      .AW   (SLOT_AW),
      .BYTE (BYTE_MODE[i]),
      .SKIP (SKIP_EN[i])
    ) u_cache (
      .clk_i   (clk),
      .rst_i   (idle),
      .cen_i   (cen),
      .addr_i  (req[i]),
      .issue_i (iss[i]),
      .cap_i   (cap[i]),
      .data_i  (data_read),
      .skip_o  (skip[i]),
      .dout_o  (slot_dout[i*16 +: 16]),
      .ok_o    (slot_ok[i])
    );
  end

  // issue for slot cnt_q and capture for pslot_q share one cen;
  // they drive separate cache ports so they never collide
  always_comb begin
    cur  = req[cnt_q];
    hit  = skip[cnt_q];
    go   = ~hit;
    word = BYTE_MODE[cnt_q] ? (cur >> 1) : cur;

    iss        = '0;
    iss[cnt_q] = go;
    cap          = '0;
    cap[pslot_q] = pend_q;

    cnt_d   = slot_sync ? '0 : cnt_q + SW'(1);
    pend_d  = go;
    pslot_d = cnt_q;
    addr_d  = go ? offs[cnt_q] + AW'(word) : addr_q;
    re_d    = re_q ^ go;
    rfsh_d  = hit & ~LVBL;

    rdy_d   = ready_q ? rdy_q : rdy_q + RW'(1);
    ready_d = ready_q | (rdy_q == RW'(READY_DLY - 1));
  end

  always_ff @(posedge clk) begin
    if (idle) begin
      cnt_q   <= '0;
      pslot_q <= '0;
      pend_q  <= 1'b0;
      addr_q  <= '0;
      re_q    <= 1'b0;
      rfsh_q  <= 1'b0;
      rdy_q   <= '0;
      ready_q <= 1'b0;
    end else if (cen) begin
      cnt_q   <= cnt_d;
      pslot_q <= pslot_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      re_q    <= re_d;
      rfsh_q  <= rfsh_d;
      rdy_q   <= rdy_d;
      ready_q <= ready_d;
    end
  end

  assign sdram_addr = addr_q;
  assign sdram_re   = re_q;
  assign sdram_rfsh = rfsh_q;
  assign ready      = ready_q;

endmodule

// File: tb/tb_jtgng_rom_slots.sv
// Bench for jtgng_rom_slots: directed scenarios plus random traffic
// against a per-cen behavioural model of the slot reader.
module tb_jtgng_rom_slots;
  import jtgng_rom_pkg::*;

  localparam int NS  = 8;
  localparam int AW  = 22;
  localparam int SAW = 18;
  localparam logic [NS*AW-1:0] OFFS_P = {
    G43_OBJ, G43_SCR2, G43_SCR1, G43_MAP2,
    G43_MAP1, G43_CHAR, 22'h0, G43_MAIN
  };
  localparam logic [NS-1:0] BYTE_P = 8'h42;
  localparam logic [NS-1:0] SKIP_P = 8'h7F;

  logic clk = 0, rst = 1, cen = 0;
  logic slot_sync = 0, downloading = 0;
  logic loop_rst = 0, LVBL = 1;
  logic [NS*SAW-1:0] slot_addr;
  logic [NS*16-1:0] slot_dout;
  logic [NS-1:0] slot_ok;
  logic [AW-1:0] sdram_addr;
  logic sdram_re, sdram_rfsh, ready;
  logic [15:0] data_read = 0;
  logic [SAW-1:0] sa [NS];

  int n_tests = 0, n_fail = 0;

  // model state
  logic [SAW-1:0] m_last [NS];
  bit m_valid [NS];
  logic [15:0] m_dout [NS];
  int m_pend, m_cnt, m_cens;
  bit m_lsb, m_re, m_rfsh, m_ready;
  logic [AW-1:0] m_addr;
  logic [NS-1:0] m_ok;

  jtgng_rom_slots #(
    .SLOTS(NS), .AW(AW), .SLOT_AW(SAW),
    .OFFSETS(OFFS_P), .BYTE_MODE(BYTE_P),
    .SKIP_EN(SKIP_P), .READY_DLY(4)
  ) dut (
    .clk(clk), .rst(rst), .cen(cen),
    .slot_sync(slot_sync),
    .downloading(downloading),
    .loop_rst(loop_rst), .LVBL(LVBL),
    .slot_addr(slot_addr),
    .slot_dout(slot_dout),
    .slot_ok(slot_ok),
    .sdram_addr(sdram_addr),
    .sdram_re(sdram_re),
    .sdram_rfsh(sdram_rfsh),
    .data_read(data_read),
    .ready(ready)
  );

  always #5 clk = ~clk;

  always_comb begin
    slot_addr = '0;
    for (int i = 0; i < NS; i++)
      slot_addr[i*SAW +: SAW] = sa[i];
  end

  function automatic logic [AW-1:0] exp_addr(input int k);
    logic [SAW-1:0] w;
    w = BYTE_P[k] ? (sa[k] >> 1) : sa[k];
    return OFFS_P[k*AW +: AW] + {4'b0, w};
  endfunction

  function automatic logic [NS*16-1:0] exp_dout();
    logic [NS*16-1:0] v;
    for (int i = 0; i < NS; i++) v[i*16 +: 16] = m_dout[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NS; i++) begin
      m_last[i] = 0; m_valid[i] = 0; m_dout[i] = 0;
    end
    m_pend = -1; m_cnt = 0; m_cens = 0;
    m_lsb = 0; m_re = 0; m_rfsh = 0; m_ready = 0;
    m_addr = 0; m_ok = 0;
  endtask

  // what one cen does, from the slot-reader rules
  task automatic model_tick();
    int k;
    m_ok = 0;
    m_rfsh = 0;
    if (rst || loop_rst || downloading) begin
      model_clear();
      return;
    end
    if (m_pend >= 0) begin
      if (BYTE_P[m_pend])
        m_dout[m_pend] = {8'h00,
          m_lsb ? data_read[7:0] : data_read[15:8]};
      else
        m_dout[m_pend] = data_read;
      m_ok[m_pend] = 1'b1;
    end
    k = m_cnt;
    if (SKIP_P[k] && m_valid[k] && m_last[k] == sa[k]) begin
      m_rfsh = !LVBL;
      m_pend = -1;
    end else begin
      m_addr = exp_addr(k);
      m_re = !m_re;
      m_last[k] = sa[k];
      m_valid[k] = 1;
      m_lsb = sa[k][0];
      m_pend = k;
    end
    m_cnt = slot_sync ? 0 : (m_cnt + 1) % NS;
    m_cens++;
    m_ready = (m_cens >= 4);
  endtask

  task automatic tick();
    @(negedge clk); cen = 1;
    @(negedge clk); cen = 0;
  endtask

  task automatic step_d(input logic [15:0] d);
    data_read = d;
    model_tick();
    tick();
  endtask

  task automatic step();
    step_d(16'($urandom));
  endtask

  task automatic goto_slot(input int k);
    for (int n = 0; n < 2*NS && m_cnt != k; n++) step();
  endtask

  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < NS; i++) sa[i] = 18'($urandom);
    repeat (3) step();
    n_tests++;
    if (sdram_addr !== 0 || sdram_re !== 0 || sdram_rfsh !== 0) begin
      n_fail++;
      $display("FAIL reset_sdram addr=%h re=%b rfsh=%b want 0/0/0",
               sdram_addr, sdram_re, sdram_rfsh);
    end
    n_tests++;
    if (slot_ok !== 0 || slot_dout !== 0 || ready !== 0) begin
      n_fail++;
      $display("FAIL reset_slots ok=%h ready=%b want 0/0 dout=0",
               slot_ok, ready);
    end
  endtask

  task automatic test_release();
    int rise = 0;
    for (int i = 0; i < NS; i++) sa[i] = {14'($urandom), 4'(i)};
    rst = 0;
    for (int i = 0; i < NS; i++) begin
      step();
      n_tests++;
      if (sdram_addr !== exp_addr(i)) begin
        n_fail++;
        $display("FAIL seq_addr slot %0d got %h want %h",
                 i, sdram_addr, exp_addr(i));
      end
      n_tests++;
      if (sdram_re !== 1'((i + 1) % 2)) begin
        n_fail++;
        $display("FAIL seq_re slot %0d got %b want %b",
                 i, sdram_re, 1'((i + 1) % 2));
      end
      if (ready === 1'b1 && rise == 0) rise = i + 1;
    end
    n_tests++;
    if (rise != 4) begin
      n_fail++;
      $display("FAIL ready_delay got %0d cens want 4", rise);
    end
  endtask

  task automatic test_word_slot();
    goto_slot(2);
    sa[2] = 18'h00123;
    step();
    n_tests++;
    if (sdram_addr !== 22'h18123) begin
      n_fail++;
      $display("FAIL word_addr got %h want 018123", sdram_addr);
    end
    step_d(16'hBEEF);
    n_tests++;
    if (slot_dout[2*16 +: 16] !== 16'hBEEF || slot_ok !== 8'h04) begin
      n_fail++;
      $display("FAIL word_data got %h ok=%h want beef ok=04",
               slot_dout[2*16 +: 16], slot_ok);
    end
    step();
    n_tests++;
    if (slot_ok[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL word_ok_pulse got %b want 0", slot_ok[2]);
    end
  endtask

  task automatic test_byte_slot();
    logic [17:0] av [2];
    logic [15:0] dv [2];
    av[0] = 18'h5; av[1] = 18'h4;
    dv[0] = 16'h00AB; dv[1] = 16'h0012;
    for (int j = 0; j < 2; j++) begin
      goto_slot(1);
      sa[1] = av[j];
      step();
      n_tests++;
      if (sdram_addr !== 22'h2) begin
        n_fail++;
        $display("FAIL byte_addr %0d got %h want 000002",
                 j, sdram_addr);
      end
      step_d(16'h12AB);
      n_tests++;
      if (slot_dout[16 +: 16] !== dv[j] || slot_ok[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL byte_data %0d got %h ok=%b want %h ok=1",
                 j, slot_dout[16 +: 16], slot_ok[1], dv[j]);
      end
    end
  endtask

  task automatic test_skip();
    bit er;
    logic [AW-1:0] ea;
    LVBL = 0;
    goto_slot(3);
    sa[3] = sa[3] ^ 18'h1;
    step();
    goto_slot(3);
    er = m_re;
    step();
    n_tests++;
    if (sdram_re !== er || sdram_rfsh !== 1'b1) begin
      n_fail++;
      $display("FAIL skip_rfsh re=%b rfsh=%b want re=%b rfsh=1",
               sdram_re, sdram_rfsh, er);
    end
    sa[4] = sa[4] ^ 18'h2;
    step();
    n_tests++;
    if (sdram_rfsh !== 0 || slot_ok[3] !== 0 ||
        slot_dout[3*16 +: 16] !== m_dout[3]) begin
      n_fail++;
      $display("FAIL skip_hold rfsh=%b ok3=%b d3=%h want 0/0/%h",
               sdram_rfsh, slot_ok[3], slot_dout[3*16 +: 16],
               m_dout[3]);
    end
    LVBL = 1;
    goto_slot(3);
    er = m_re;
    ea = m_addr;
    step();
    n_tests++;
    if (sdram_re !== er || sdram_addr !== ea || sdram_rfsh !== 0) begin
      n_fail++;
      $display("FAIL skip_idle re=%b a=%h rfsh=%b want %b/%h/0",
               sdram_re, sdram_addr, sdram_rfsh, er, ea);
    end
  endtask

  task automatic test_idle_mid();
    LVBL = 0;
    goto_slot(5);
    sa[5] = sa[5] ^ 18'h4;
    step();
    loop_rst = 1;
    step();
    n_tests++;
    if (slot_ok !== 0 || slot_dout !== 0 || ready !== 0 ||
        sdram_addr !== 0 || sdram_re !== 0) begin
      n_fail++;
      $display("FAIL idle_clear ok=%h rdy=%b a=%h re=%b want zeros",
               slot_ok, ready, sdram_addr, sdram_re);
    end
    loop_rst = 0;
    for (int i = 0; i < NS; i++) begin
      step();
      n_tests++;
      if (sdram_addr !== exp_addr(i) || sdram_rfsh !== 0 ||
          sdram_re !== 1'((i + 1) % 2) ||
          ready !== (i >= 3)) begin
        n_fail++;
        $display("FAIL reread %0d a=%h re=%b rf=%b rdy=%b want %h",
                 i, sdram_addr, sdram_re, sdram_rfsh, ready,
                 exp_addr(i));
      end
    end
    LVBL = 1;
  endtask

  task automatic test_sync();
    goto_slot(5);
    for (int i = 0; i < NS; i++) sa[i] = sa[i] ^ 18'h100;
    slot_sync = 1;
    step();
    slot_sync = 0;
    n_tests++;
    if (sdram_addr !== exp_addr(5)) begin
      n_fail++;
      $display("FAIL sync_issue5 got %h want %h",
               sdram_addr, exp_addr(5));
    end
    step();
    n_tests++;
    if (sdram_addr !== exp_addr(0) || slot_ok[5] !== 1'b1) begin
      n_fail++;
      $display("FAIL sync_slot0 got %h ok5=%b want %h ok5=1",
               sdram_addr, slot_ok[5], exp_addr(0));
    end
    for (int k = 1; k < 3; k++) begin
      step();
      n_tests++;
      if (sdram_addr !== exp_addr(k)) begin
        n_fail++;
        $display("FAIL sync_slot%0d got %h want %h",
                 k, sdram_addr, exp_addr(k));
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < NS; i++)
        if ($urandom_range(0, 3) == 0)
          sa[i] = ($urandom_range(0, 1) == 0) ?
                  18'($urandom) : sa[i] ^ 18'h1;
      LVBL        = ($urandom_range(0, 3) != 0);
      slot_sync   = ($urandom_range(0, 15) == 0);
      loop_rst    = ($urandom_range(0, 49) == 0);
      downloading = ($urandom_range(0, 69) == 0);
      step();
      n_tests++;
      if (sdram_addr !== m_addr || sdram_re !== m_re ||
          sdram_rfsh !== m_rfsh) begin
        n_fail++;
        $display("FAIL rnd_sdram t=%0d a=%h re=%b rf=%b want %h/%b/%b",
                 t, sdram_addr, sdram_re, sdram_rfsh,
                 m_addr, m_re, m_rfsh);
      end
      n_tests++;
      if (slot_ok !== m_ok || ready !== m_ready) begin
        n_fail++;
        $display("FAIL rnd_ok t=%0d ok=%h rdy=%b want %h/%b",
                 t, slot_ok, ready, m_ok, m_ready);
      end
      n_tests++;
      if (slot_dout !== exp_dout()) begin
        n_fail++;
        $display("FAIL rnd_dout t=%0d got %h want %h",
                 t, slot_dout, exp_dout());
      end
    end
    slot_sync = 0; loop_rst = 0; downloading = 0; LVBL = 1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1);
  end

  initial begin
    model_clear();
    test_reset();
    test_release();
    test_word_slot();
    test_byte_slot();
    test_skip();
    test_idle_mid();
    test_sync();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtgng_rom_slots.md
Name: jtgng_rom_slots

Overview:
- Parametrised successor of the fixed per-game SDRAM ROM time-slot reader.
- Serves SLOTS requesters (main/sound CPU, char, scroll, map, obj) from one 16-bit SDRAM read port, one slot per enabled cen cycle in a fixed round-robin.
- Adds four things: per-slot offsets and byte/word mode, skipping of repeated addresses, auto-refresh insertion in vertical blank, and per-slot data-valid strobes.
- Sits between the game video/CPU address generators and the SDRAM controller.

Parameters:
- SLOTS, 8, number of slots; power of two, 2..16.
- AW, 22, SDRAM word address width.
- SLOT_AW, 18, width of each slot's request address.
- OFFSETS, {SLOTS*AW{1'b0}}, packed per-slot base word address; slot i uses bits [i*AW +: AW].
- BYTE_MODE, {SLOTS{1'b0}}, bit i=1: slot i address is a byte address; word = addr>>1, addr[0] selects the byte.
- SKIP_EN, {SLOTS{1'b1}}, bit i=1: slot i may skip its read when the address is unchanged.
- READY_DLY, 4, cen cycles after loop_rst/downloading release before ready rises.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cen  in  1  slot clock enable (12 MHz)
- slot_sync  in  1  forces the slot counter to 0 on the next cen (pixel-tuple alignment)
- downloading  in  1  ROM download active; holds the block idle
- loop_rst  in  1  SDRAM loop reset; holds the block idle
- LVBL  in  1  active-low vertical blank
- slot_addr  in  SLOTS*SLOT_AW  packed request addresses
- slot_dout  out  SLOTS*16  packed read data; byte slots use the low 8 bits, upper 8 bits zero
- slot_ok  out  SLOTS  one-cen pulse when slot_dout[i] is updated
- sdram_addr  out  AW  read word address
- sdram_re  out  1  toggles once per issued read
- sdram_rfsh  out  1  one-cen refresh request pulse
- data_read  in  16  SDRAM data, valid one cen after its address
- ready  out  1  high once the read pipeline is primed

Behaviour:
- All state and outputs update only on cen, except reset/idle handling.
- Reset, and idle while (loop_rst || downloading), which is applied on every clk:
  - slot counter = 0; sdram_addr = 0; sdram_re = 0; sdram_rfsh = 0.
  - slot_dout all 0; slot_ok = 0; ready = 0.
  - all last-address registers invalid; ready counter cleared.
- Slot counter cnt: increments modulo SLOTS each cen. When slot_sync=1 on a cen, cnt loads 0 on that cen.
- Issue, at the cen where cnt=k:
  - word = BYTE_MODE[k] ? slot_addr_k>>1 : slot_addr_k.
  - Skip rule: if SKIP_EN[k], last-address valid, and slot_addr_k equals the stored address, there is no read.
    - If !LVBL, sdram_rfsh pulses instead.
    - Otherwise the cycle is idle, and sdram_re and sdram_addr hold.
  - Else: sdram_addr <= OFFSETS[k] + word, with the word zero-extended to AW and the sum truncated to AW bits. sdram_re toggles; the stored address and the lsb are latched for slot k.
- Capture, at the cen after a read was issued for slot k:
  - Word slot: slot_dout[k] <= data_read.
  - Byte slot: slot_dout[k] <= lsb ? data_read[7:0] : data_read[15:8].
  - slot_ok[k] pulses for one cen.
  - Skipped slots get no capture and no slot_ok; slot_dout holds.
- Latency: address at slot k, data registered one cen later. Request-to-data is at most SLOTS+1 cens.
- The issue pipeline is 1 deep. Issuing at slot k+1 and capturing for slot k happen on the same cen and must not interfere.
- ready:
  - Shift counter counts cens after idle release; ready rises READY_DLY cens after release.
  - ready stays high until the next idle or reset.
- Idle asserted mid-operation: the pending capture is discarded immediately, with no slot_ok.
- Wrap: cnt SLOTS-1 -> 0 is seamless; a slot_sync on the wrap cen gives the same result.
- sdram_rfsh never asserts while LVBL=1.

Decomposition:
- Package jtgng_rom_pkg: slot index width function (clog2 of SLOTS) and the default OFFSETS layout constants for 1943, namely SND 0x14000, CHAR 0x18000, MAP1 0x1C000, MAP2 0x20000, SCR1 0x24000, SCR2 0x44000, OBJ 0x4C000.
- Sub-module jtgng_rom_slot_cache, one per slot: holds the last address, the valid bit, the lsb and the data register, and produces the skip flag.

Test Plan:
- Reset, then release with SLOTS=8 and all addresses distinct → ready rises 4 cens after release. sdram_re toggles every cen. sdram_addr sequence = OFFSETS[k]+addr_k for k=0..7.
- Slot 2 word mode, OFFSETS[2]=0x18000, addr 0x0123, data_read=0xBEEF on the next cen → sdram_addr=0x18123. slot_dout[2]=0xBEEF, slot_ok[2] pulses once.
- Slot 1 byte mode, addr 0x00005, data 0x12AB → sdram_addr=0x00002, slot_dout[1]=0x00AB. With addr 0x00004 → 0x0012.
- Slot 3 address constant across two rounds, LVBL=0 → second round: no sdram_re toggle, sdram_rfsh=1 for one cen, slot_dout[3] unchanged. Same with LVBL=1 → idle cycle, no refresh.
- loop_rst asserted right after slot 5 issues → no slot_ok[5]; all slot_dout=0, ready=0; after release the first round re-reads every slot, with no skips.
- slot_sync pulsed while cnt=5 → next issued slot is 0; sequence continues 1, 2, …; the capture for slot 5 still completes.
